// File: rtl/sobel_window_gen_if.sv
// Pixel stream in, 3x3 window out, for the sobel window generator.
//   pix_in / pix_valid / sof : raster pixel stream (driven by the source)
//   p0..p8                   : window taps, PIX_W+1 bits, zero-extended
//   win_valid                : taps hold a complete window this cycle
// master = pixel source / window consumer, slave = window generator.
interface sobel_window_gen_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             sof;
    logic [PIX_W:0]   p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic             win_valid;

    modport master (
        output pix_in, pix_valid, sof,
        input  p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-window front end for the sobel gradient stage.
// Buffers two image lines and emits a registered 3x3 neighbourhood one
// cycle after every accepted pixel that completes one.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sobel_window_gen_if (pixel stream in,
//                taps p0..p8 + win_valid out)
module sobel_window_gen #(
    parameter int IMG_W = 64,
    parameter int PIX_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_window_gen_if.slave bus
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    logic [COL_W-1:0] col, col_eff;
    logic [1:0]       row, row_eff;
    logic             accept;

    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    logic [PIX_W-1:0] win [9];
    logic             win_valid_q;

    // sof forces the current pixel to (0,0) without waiting for a counter update
    always_comb begin
        accept  = bus.pix_valid;
        col_eff = bus.sof ? '0 : col;
        row_eff = bus.sof ? '0 : row;
        lb0_rd  = lb0[col_eff];
        lb1_rd  = lb1[col_eff];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_eff == COL_LAST) begin
                col <= '0;
                row <= (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
            end else begin
                col <= col_eff + COL_W'(1);
                row <= row_eff;
            end
        end
    end

    // Line memory is not reset; stale contents are masked by row.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_eff] <= lb1_rd;
            lb1[col_eff] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= accept && (row_eff == 2'd2) && (col_eff >= COL_W'(2));
            if (accept) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb0_rd;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb1_rd;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= bus.pix_in;
            end
        end
    end

    assign bus.p0        = {1'b0, win[0]};
    assign bus.p1        = {1'b0, win[1]};
    assign bus.p2        = {1'b0, win[2]};
    assign bus.p3        = {1'b0, win[3]};
    assign bus.p4        = {1'b0, win[4]};
    assign bus.p5        = {1'b0, win[5]};
    assign bus.p6        = {1'b0, win[6]};
    assign bus.p7        = {1'b0, win[7]};
    assign bus.p8        = {1'b0, win[8]};
    assign bus.win_valid = win_valid_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized self-checking bench for sobel_window_gen (IMG_W=5).
// Reference: every pixel accepted since the last sof/reset is kept in a
// queue; pixel n sits at line n/W, column n%W, and its window is read
// straight out of that history.
module tb_sobel_window_gen;
    localparam int W     = 5;
    localparam int PIX_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_window_gen_if #(.PIX_W(PIX_W)) bus_if ();

    sobel_window_gen #(.IMG_W(W), .PIX_W(PIX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] hist[$];
    logic [7:0] exp_tap [9];
    logic       taps_known = 1'b0;
    int         win_cnt = 0;
    int         acc_cnt = 0;
    int         first_win_at = -1;

    task automatic chk(input string tag, input int got, input int expv);
        tests_run++;
        if (got != expv) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    function automatic int tap(input int k);
        case (k)
            0: return int'(bus_if.p0);
            1: return int'(bus_if.p1);
            2: return int'(bus_if.p2);
            3: return int'(bus_if.p3);
            4: return int'(bus_if.p4);
            5: return int'(bus_if.p5);
            6: return int'(bus_if.p6);
            7: return int'(bus_if.p7);
            default: return int'(bus_if.p8);
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_wv"}, int'(bus_if.win_valid), 0);
        for (int k = 0; k < 9; k++) chk({tag, "_tap"}, tap(k), 0);
    endtask

    // One clock: drive inputs, let the edge pass, update model, compare.
    task automatic cycle(input logic v, input logic s, input logic [7:0] px);
        int  n;
        logic exp_wv;
        bus_if.pix_valid = v;
        bus_if.sof       = s;
        bus_if.pix_in    = px;
        @(posedge clk);
        #1;
        exp_wv = 1'b0;
        if (v) begin
            if (s) hist.delete();
            hist.push_back(px);
            acc_cnt++;
            n = hist.size() - 1;
            exp_wv = ((n / W) >= 2) && ((n % W) >= 2);
            if (exp_wv) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_tap[3*i+j] = hist[n - (2-i)*W - (2-j)];
                taps_known = 1'b1;
            end else begin
                taps_known = 1'b0;
            end
        end
        chk("win_valid", int'(bus_if.win_valid), int'(exp_wv));
        if (taps_known)
            for (int k = 0; k < 9; k++) chk("tap", tap(k), int'({1'b0, exp_tap[k]}));
        if (bus_if.win_valid) begin
            win_cnt++;
            if (first_win_at < 0) first_win_at = acc_cnt;
        end
        bus_if.pix_valid = 1'b0;
        bus_if.sof       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        bus_if.pix_valid = 1'b0;
        bus_if.sof       = 1'b0;
        bus_if.pix_in    = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // ramp frame
        win_cnt = 0;
        for (int i = 0; i < 25; i++) cycle(1'b1, i == 0, 8'(i));
        idle(1);
        chk("ramp_windows", win_cnt, 9);

        // gapped ramp frame
        win_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, i == 0, 8'(i));
            idle(1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        chk("gapped_windows", win_cnt, 9);

        // mid-frame sof after 7 pixels
        for (int i = 0; i < 7; i++) cycle(1'b1, i == 0, 8'(200 + i));
        win_cnt = 0;
        for (int i = 0; i < 25; i++) cycle(1'b1, i == 0, 8'(i));
        idle(1);
        chk("restart_windows", win_cnt, 9);

        // sof right after a window-producing pixel: in-flight window completes
        for (int i = 0; i < 13; i++) cycle(1'b1, i == 0, 8'($urandom));
        for (int i = 0; i < 25; i++) cycle(1'b1, i == 0, 8'($urandom));

        // random traffic, random gaps, occasional sof, frames running on
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0, 8'($urandom));

        // all-ones frame, then three more pixels into the next line
        win_cnt = 0;
        for (int i = 0; i < 25; i++) cycle(1'b1, i == 0, 8'hFF);
        chk("ff_windows", win_cnt, 9);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hFF);

        // async reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist.delete();
        for (int k = 0; k < 9; k++) exp_tap[k] = '0;
        taps_known = 1'b1;
        acc_cnt = 0;
        first_win_at = -1;
        for (int i = 0; i < 300 && acc_cnt < 2*W + 8; i++)
            cycle($urandom_range(0, 2) != 0, 1'b0, 8'($urandom));
        chk("first_win_after_rst", first_win_at, 2*W + 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window front end for the sobel edge datapath. It accepts one 8-bit pixel per valid cycle in row-major order and buffers two full image lines internally. For every input pixel whose position completes a 3x3 neighbourhood, it presents that neighbourhood as nine 9-bit zero-extended taps. These taps drive the p0..p8 inputs of the sobel gradient stage directly.

## Interface
- IMG_W, 64: pixels per image line; legal range 3..1024.
- PIX_W, 8: input pixel width. Taps are PIX_W+1 bits wide, zero-extended.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_in  in  PIX_W  incoming pixel.
- pix_valid  in  1  pix_in is valid this cycle.
- sof  in  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0).
- p0..p8  out  PIX_W+1 each  window taps.
  - Row-major layout: p0 p1 p2 / p3 p4 p5 / p6 p7 p8.
  - p0 is the oldest row, leftmost column.
  - p8 is the newest pixel.
- win_valid  out  1  p0..p8 hold a complete window this cycle.

## Operation
- **Counters**
  - col runs 0..IMG_W-1 and wraps to 0 after IMG_W-1.
  - On wrap, row increments. row saturates at 2, which means "two lines buffered".
  - Counters advance only on cycles with pix_valid=1.
- **sof**
  - On a cycle with pix_valid=1 and sof=1, the pixel is taken as (0,0).
  - col and row are treated as 0 for that pixel. They become col=1, row=0 afterwards, or col=0, row=1 if IMG_W wraps.
  - Line-buffer contents are not cleared; they are masked by row.
  - sof with pix_valid=0 is ignored.
- **Line buffers**
  - lb1 holds the previous line; lb0 holds the line before that.
  - Each is IMG_W x PIX_W, indexed by col.
  - On each accepted pixel: read lb0[col] and lb1[col], write lb0[col] <= lb1[col], write lb1[col] <= pix_in.
  - This is read-before-write at the same address in the same cycle.
- **Shift window**
  - Three 3-deep column shift registers: top, mid, bottom.
  - On each accepted pixel, the column {lb0[col], lb1[col], pix_in} shifts in on the right.
  - After the shift, p2 = lb0[col], p5 = lb1[col], p8 = pix_in.
  - The window does not reset at line boundaries. Windows spanning a line wrap are suppressed via win_valid.
- **win_valid** = 1 for exactly one cycle after an accepted pixel at (row>=2, col>=2), evaluated before the counter update. Otherwise 0.
- **Output count**
  - (H-2)*(IMG_W-2) windows per frame of H lines.
  - Line 0, line 1, column 0 and column 1 of every line produce no window.
- **Frame end** is implicit. Pixels after the last line simply continue as further lines until the next sof.
- **Taps**
  - Registered. Zero-extended: bit PIX_W is always 0.
  - Taps hold their value while pix_valid=0.

## Timing
- Latency: 1 cycle from accepted pixel to win_valid and taps.
- No backpressure. One pixel per cycle is sustainable indefinitely; pix_valid gaps of any length are allowed.
- win_valid never asserts on a cycle following pix_valid=0.
- **Reset** (async assert, sync release by the system):
  - win_valid=0, p0..p8=0, col=0, row=0.
  - Line-buffer memory is not reset.
  - The first pixel after reset is treated as (0,0) even without sof.
- Reset mid-frame aborts the frame. No window appears until two full lines plus three pixels have been accepted again.
- sof arriving mid-line restarts geometry immediately. A window in flight from the prior pixel still completes its one-cycle win_valid.

## Test plan
- **Ramp frame.** IMG_W=5; stream pixels 0..24 with sof on pixel 0.
  - First win_valid follows pixel 12, with p0..p8 = 0,1,2,5,6,7,10,11,12.
  - Exactly 9 windows total; the last has p8=24, p0=12.
- **Gapped input.** Same frame with pix_valid toggled 1/0 every cycle and random idle bursts.
  - Identical window sequence; win_valid only on cycles after accepted pixels.
- **Mid-frame sof.** Send 7 ramp pixels, then restart with sof and a 0..24 ramp.
  - No window until the restarted pixel 12; contents as in the ramp-frame test.
- **Line wrap suppression.** IMG_W=5.
  - win_valid=0 after pixels at col 0 and col 1 of every line ≥2 (indices 10,11,15,16,20,21).
- **Width extension.** Constant pix_in=8'hFF frame.
  - All taps = 9'h0FF when win_valid=1.
- **Async reset mid-frame.** Assert rst_n=0 mid-line.
  - Outputs go to 0 without a clock edge.
  - After release, the first window appears after 2*IMG_W+3 accepted pixels.
